// File: rtl/result_collector_pkg.sv
// Shared types and defaults for the result collector: FSM encoding, default
// geometry and the one-step signature update.
package result_collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        DONE    = 2'b10
    } state_t;

    localparam int DEF_N  = 64;
    localparam int DEF_DW = 1024;
    localparam int SIG_W  = 32;

    // Rotate-left-by-one then XOR in the folded word; pure bit operations, no carries.
    function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                  input logic [SIG_W-1:0] fold);
        return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ fold;
    endfunction

endpackage

// File: rtl/xor_fold_sig.sv
// Combinational fold of a DW-bit word to 32 bits by XOR-ing its 32-bit slices.
module xor_fold_sig
    import result_collector_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic [DW-1:0]    i_data,
    output logic [SIG_W-1:0] o_fold
);

    localparam int SLICES = DW / SIG_W;

    if (DW % SIG_W != 0) begin : g_bad_dw
        $error("xor_fold_sig: DW must be a multiple of 32");
    end

    always_comb begin
        o_fold = '0;
        for (int i = 0; i < SLICES; i++) begin
            o_fold = o_fold ^ i_data[i*SIG_W +: SIG_W];
        end
    end

endmodule

// File: rtl/result_collector.sv
// Captures one pass of N result words in arrival order, keeps a running XOR
// signature and offers a registered read-first readback port plus pass status.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int AW = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             valid_in,
    input  logic [DW-1:0]    data_in,
    input  logic [AW-1:0]    rd_addr,
    output logic [DW-1:0]    rd_data,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [AW:0]      word_count,
    output logic [SIG_W-1:0] signature,
    output logic [1:0]       dbg_state
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(N - 1);
    localparam logic [AW:0] DEPTH    = (AW+1)'(N);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_overflow;
    logic [AW:0]      r_count;
    logic [SIG_W-1:0] r_sig;
    logic [DW-1:0]    r_rd_data;
    logic [DW-1:0]    r_mem [N];

    logic [SIG_W-1:0] w_fold;
    logic             w_wr_en;
    logic             w_rd_in_range;

    xor_fold_sig #(.DW(DW)) u_fold (
        .i_data (data_in),
        .o_fold (w_fold)
    );

    // start outranks a coincident valid_in, so a restarting word is never stored.
    assign w_wr_en       = (r_state == COLLECT) && valid_in && !start;
    assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= '0;
            r_sig      <= '0;
        end else if (start) begin
            r_state    <= COLLECT;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= '0;
            r_sig      <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (valid_in) begin
                        r_count <= r_count + 1'b1;
                        r_sig   <= sig_step(r_sig, w_fold);
                        if (r_count == LAST_IDX) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (valid_in) begin
                        r_overflow <= 1'b1;
                    end
                end
                IDLE: begin
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_count[AW-1:0]] <= data_in;
        end
    end

    // Non-blocking read of the array gives read-first behaviour on a same-address write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (w_rd_in_range) begin
            r_rd_data <= r_mem[rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign rd_data    = r_rd_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign word_count = r_count;
    assign signature  = r_sig;
    assign dbg_state  = r_state;

endmodule
